// File: rtl/m_ext_pkg.sv
// Shared types and constants for the RV32M sequencer and its result fix-up datapath.
package m_ext_pkg;

    localparam int unsigned XLEN_DEF = 32;

    // Encodings follow RV32M funct3 directly so the request field can be cast in place.
    typedef enum logic [2:0] {
        F3Mul    = 3'd0,
        F3Mulh   = 3'd1,
        F3Mulhsu = 3'd2,
        F3Mulhu  = 3'd3,
        F3Div    = 3'd4,
        F3Divu   = 3'd5,
        F3Rem    = 3'd6,
        F3Remu   = 3'd7
    } funct3_e;

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StWait,
        StFixup,
        StDone
    } state_e;

    localparam logic [XLEN_DEF-1:0] DIV_OVF_DIVIDEND = 32'h8000_0000;
    localparam logic [XLEN_DEF-1:0] ALL_ONES         = 32'hFFFF_FFFF;

    // rs1 is treated as signed for MULH, MULHSU, DIV and REM.
    function automatic logic rs1_is_signed(input funct3_e f);
        return (f == F3Mulh) || (f == F3Mulhsu) || (f == F3Div) || (f == F3Rem);
    endfunction

    // rs2 is treated as signed for MULH, DIV and REM.
    function automatic logic rs2_is_signed(input funct3_e f);
        return (f == F3Mulh) || (f == F3Div) || (f == F3Rem);
    endfunction

endpackage

// File: rtl/m_ext_sign_fix.sv
// Turns the unsigned core result back into the architectural RV32M result.
module m_ext_sign_fix
    import m_ext_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEF
) (
    input  funct3_e             funct3_i,
    input  logic                sign_a_i,
    input  logic                sign_b_i,
    input  logic [2*XLEN-1:0]   core_result_i,
    output logic [XLEN-1:0]     result_o
);

    logic              neg_prod;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo;
    logic [XLEN-1:0]   rem;

    // Sign-correct the full-width product and the quotient/remainder, then select.
    always_comb begin
        neg_prod = sign_a_i ^ sign_b_i;
        prod     = neg_prod ? (~core_result_i + 1'b1) : core_result_i;
        quo      = core_result_i[XLEN-1:0];
        rem      = core_result_i[2*XLEN-1:XLEN];
        if (neg_prod) begin
            quo = ~quo + 1'b1;
        end
        // Remainder takes the sign of the dividend.
        if (sign_a_i) begin
            rem = ~rem + 1'b1;
        end
        case (funct3_i)
            F3Mul:                       result_o = prod[XLEN-1:0];
            F3Mulh, F3Mulhsu, F3Mulhu:   result_o = prod[2*XLEN-1:XLEN];
            F3Div, F3Divu:               result_o = quo;
            F3Rem, F3Remu:               result_o = rem;
            default:                     result_o = '0;
        endcase
    end

endmodule

// File: rtl/m_ext_sequencer.sv
// RV32M sequencer: converts operands to magnitudes, drives the multiply/divide core,
// resolves divide special cases locally and applies sign correction to the result.
module m_ext_sequencer
    import m_ext_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEF
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              req_valid_i,
    input  logic [2:0]        req_funct3_i,
    input  logic [XLEN-1:0]   req_rs1_i,
    input  logic [XLEN-1:0]   req_rs2_i,
    output logic              resp_valid_o,
    output logic [XLEN-1:0]   resp_result_o,
    output logic              stall_o,
    output logic              core_execute_o,
    output logic              core_div_o,
    output logic [XLEN-1:0]   core_a_o,
    output logic [XLEN-1:0]   core_b_o,
    input  logic              core_ready_i,
    input  logic [2*XLEN-1:0] core_result_i
);

    state_e            state_q, state_d;
    funct3_e           funct3_q, funct3_d;
    logic              sign_a_q, sign_a_d;
    logic              sign_b_q, sign_b_d;
    logic [XLEN-1:0]   a_q, a_d;
    logic [XLEN-1:0]   b_q, b_d;
    logic [2*XLEN-1:0] res_q, res_d;
    logic [XLEN-1:0]   result_q, result_d;

    funct3_e           req_f3;
    logic              req_sa, req_sb, req_is_div, div_zero, div_ovf;
    logic [XLEN-1:0]   mag_a, mag_b;
    logic [XLEN-1:0]   fixed_result;

    // Decode the incoming request: sign flags, magnitudes and divide special cases.
    always_comb begin
        req_f3     = funct3_e'(req_funct3_i);
        req_sa     = rs1_is_signed(req_f3) & req_rs1_i[XLEN-1];
        req_sb     = rs2_is_signed(req_f3) & req_rs2_i[XLEN-1];
        mag_a      = req_sa ? (~req_rs1_i + 1'b1) : req_rs1_i;
        mag_b      = req_sb ? (~req_rs2_i + 1'b1) : req_rs2_i;
        req_is_div = req_funct3_i[2];
        div_zero   = req_is_div && (req_rs2_i == '0);
        div_ovf    = req_is_div && rs2_is_signed(req_f3) &&
                     (req_rs1_i == DIV_OVF_DIVIDEND) && (req_rs2_i == ALL_ONES);
    end

    m_ext_sign_fix #(
        .XLEN          (XLEN)
    ) u_sign_fix (
        .funct3_i      (funct3_q),
        .sign_a_i      (sign_a_q),
        .sign_b_i      (sign_b_q),
        .core_result_i (res_q),
        .result_o      (fixed_result)
    );

    // Next-state logic and per-state output pulses.
    always_comb begin
        state_d        = state_q;
        funct3_d       = funct3_q;
        sign_a_d       = sign_a_q;
        sign_b_d       = sign_b_q;
        a_d            = a_q;
        b_d            = b_q;
        res_d          = res_q;
        result_d       = result_q;
        core_execute_o = 1'b0;
        resp_valid_o   = 1'b0;
        case (state_q)
            StIdle: begin
                if (req_valid_i) begin
                    funct3_d = req_f3;
                    sign_a_d = req_sa;
                    sign_b_d = req_sb;
                    a_d      = mag_a;
                    b_d      = mag_b;
                    // Special cases preload a fake core result with the signs cleared so
                    // the fix-up stage passes it through untouched.
                    if (div_zero) begin
                        res_d    = {req_rs1_i, ALL_ONES};
                        sign_a_d = 1'b0;
                        sign_b_d = 1'b0;
                        state_d  = StFixup;
                    end else if (div_ovf) begin
                        res_d    = {{XLEN{1'b0}}, DIV_OVF_DIVIDEND};
                        sign_a_d = 1'b0;
                        sign_b_d = 1'b0;
                        state_d  = StFixup;
                    end else begin
                        state_d  = StIssue;
                    end
                end
            end
            StIssue: begin
                core_execute_o = 1'b1;
                state_d        = StWait;
            end
            StWait: begin
                if (core_ready_i) begin
                    res_d   = core_result_i;
                    state_d = StFixup;
                end
            end
            StFixup: begin
                result_d = fixed_result;
                state_d  = StDone;
            end
            StDone: begin
                resp_valid_o = 1'b1;
                state_d      = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= StIdle;
            funct3_q <= F3Mul;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            funct3_q <= funct3_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            a_q      <= a_d;
            b_q      <= b_d;
            res_q    <= res_d;
            result_q <= result_d;
        end
    end

    assign core_div_o    = funct3_q[2];
    assign core_a_o      = a_q;
    assign core_b_o      = b_q;
    assign resp_result_o = result_q;
    assign stall_o       = req_valid_i & ~resp_valid_o;

endmodule

// File: doc/m_ext_sequencer.md
Name: m_ext_sequencer

Overview:
- Sits between the execute stage and the shift/add multiply-divide core. Accepts one RV32M instruction (funct3 + rs1/rs2) and converts signed operands to magnitudes.
- Starts the core, waits for its ready pulse, then applies sign correction and result selection.
- Divide-by-zero and signed-overflow cases resolve locally without starting the core.
- Holds the pipeline stalled until the result is returned.

Parameters:
- XLEN, 32, operand/result width; core result width is 2*XLEN.

Ports:
- Clk  in  1  clock, all state on rising edge
- Reset  in  1  synchronous, active-high reset
- req_valid  in  1  instruction present; held high with stable operands until resp_valid
- req_funct3  in  3  0=MUL 1=MULH 2=MULHSU 3=MULHU 4=DIV 5=DIVU 6=REM 7=REMU
- req_rs1  in  XLEN  operand A / dividend
- req_rs2  in  XLEN  operand B / divisor
- resp_valid  out  1  one-cycle pulse; resp_result valid this cycle
- resp_result  out  XLEN  final architectural result
- stall  out  1  combinational: req_valid & ~resp_valid
- core_execute  out  1  one-cycle start pulse to core
- core_div  out  1  1=divide, 0=multiply; held stable while core busy
- core_a  out  XLEN  unsigned magnitude A, held stable while core busy
- core_b  out  XLEN  unsigned magnitude B, held stable while core busy
- core_ready  in  1  one-cycle done pulse from core
- core_result  in  2*XLEN  multiply: full product; divide: {remainder, quotient}

Behaviour:
- Reset values: state=IDLE; resp_valid=0, resp_result=0, core_execute=0, core_div=0, core_a=0, core_b=0; all internal registers cleared.
- IDLE: on req_valid, latch funct3 and the operand sign flags, then compute magnitudes.
  - MUL, MULHU, DIVU, REMU: both operands unsigned.
  - MULH, DIV, REM: both signed.
  - MULHSU: rs1 signed, rs2 unsigned.
  - Divide with rs2==0 -> FIXUP, special zero-divide.
  - Signed divide with rs1==0x80000000 and rs2==0xFFFFFFFF -> FIXUP, special overflow.
  - Otherwise -> ISSUE.
- ISSUE (1 cycle): core_execute=1, core_div=funct3[2] -> WAIT.
- WAIT: core_execute=0. On core_ready, latch core_result -> FIXUP. No timeout; latency is set by the core.
- FIXUP (1 cycle): compute resp_result -> DONE.
  - neg_prod = sA ^ sB.
  - MUL: low half of product.
  - MULH/MULHSU/MULHU: high half of the 2*XLEN two's-complement product, negated when neg_prod.
  - DIV/DIVU: quotient, negated when sA ^ sB (signed only).
  - REM/REMU: remainder, negated when sA (signed only).
  - Zero-divide: quotient=all ones, remainder=rs1.
  - Overflow: quotient=0x80000000, remainder=0.
- DONE (1 cycle): resp_valid=1 -> IDLE. resp_result holds its value until the next FIXUP.
- Back-to-back: a new req_valid in the cycle after DONE is accepted normally.
- Minimum latency: special cases req->resp = 3 cycles; core path = 3 + core latency.
- Boundary cases:
  - core_ready seen outside WAIT: ignored.
  - req operand changes while busy: ignored; latched copies are used.
  - Reset mid-operation, any state: IDLE next edge, core_execute=0, no resp_valid.
  - The core self-returns to idle after its ready pulse; no abort signal is needed.
- Negation uses two's complement at full width. Magnitude of 0x80000000 is 0x80000000 unsigned.

Decomposition:
- Shared package m_ext_pkg holds:
  - funct3 enum (MUL..REMU)
  - state enum (IDLE, ISSUE, WAIT, FIXUP, DONE)
  - constants DIV_OVF_DIVIDEND=0x80000000 and ALL_ONES
- One combinational sub-module, m_ext_sign_fix: inputs funct3, sign flags, 2*XLEN core result; output XLEN corrected result. Keeps the FSM file free of datapath.

Test Plan:
- MULH rs1=0xFFFFFFFF rs2=0xFFFFFFFF -> core_a=core_b=1; resp_result=0x00000000. Same operands with MULHU -> 0xFFFFFFFE; with MUL -> 0x00000001.
- DIV rs1=0xFFFFFFF9 (-7) rs2=2 -> core_a=7, core_b=2; resp_result=0xFFFFFFFD. Same with REM -> 0xFFFFFFFF.
- DIVU rs1=0x1234 rs2=0 -> core_execute never asserted; resp_valid 3 cycles after req; resp_result=0xFFFFFFFF. REMU same operands -> 0x1234.
- DIV rs1=0x80000000 rs2=0xFFFFFFFF -> no core start; resp_result=0x80000000. REM same operands -> 0.
- MULHSU rs1=0xFFFFFFFE (-2) rs2=0x80000000 -> resp_result=0xFFFFFFFF. Then a back-to-back MUL 3*5 in the cycle after DONE -> resp_result=15; stall low only on each resp_valid cycle.
- Assert Reset during WAIT, with a spurious core_ready after reset -> IDLE, no resp_valid, outputs at reset values; the next request completes correctly.
